// File: rtl/step_motor_drv_pkg.sv
// Shared definitions for the stepper axis: FSM encoding, direction levels
// and the shortest legal step period.
package axis_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } axis_state_e;

  localparam logic DIR_POS    = 1'b0;
  localparam logic DIR_NEG    = 1'b1;
  localparam int   MIN_PERIOD = 2;

endpackage

// File: rtl/step_motor_drv_if.sv
// Command/status bundle between the axis motion controller (master) and the
// step-pulse generator (slave).
// Handshake: start, stop and mod_remain are single-cycle strobes sampled on the
// rising clock edge; there is no ready, the strobes are simply ignored in states
// where they have no meaning.
interface step_motor_drv_if #(
  parameter int NW = 32,
  parameter int SW = 32
) ();

  logic                 sel;
  logic                 start;
  logic                 stop;
  logic [SW-1:0]        speed;
  logic signed [NW-1:0] step;
  logic                 abs;
  logic                 mod_remain;
  logic signed [NW-1:0] new_remain;

  logic                 state;
  logic                 rt_dir;
  logic signed [NW-1:0] position;
  logic                 ntsign;
  logic                 zpsign;
  logic                 ptsign;

  modport master (
    output sel, start, stop, speed, step, abs, mod_remain, new_remain,
    input  state, rt_dir, position, ntsign, zpsign, ptsign
  );

  modport slave (
    input  sel, start, stop, speed, step, abs, mod_remain, new_remain,
    output state, rt_dir, position, ntsign, zpsign, ptsign
  );

endinterface

// File: rtl/step_motor_drv_sync2.sv
// Two-flop synchronizer for a single asynchronous sensor level.
module sync2 (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic dout
);

  logic meta_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q <= 1'b0;
      dout   <= 1'b0;
    end else begin
      meta_q <= din;
      dout   <= meta_q;
    end
  end

endmodule

// File: rtl/step_motor_drv.sv
// Step-pulse generator for one stepper axis: turns accepted moves into a train
// of fixed-period step pulses plus a direction level, tracking absolute position.
module step_motor_drv
  import axis_pkg::*;
#(
  parameter int C_STEP_NUMBER_WIDTH = 32,
  parameter int C_SPEED_DATA_WIDTH  = 32
) (
  input  logic             clk,
  input  logic             resetn,
  step_motor_drv_if.slave  ctrl,
  input  logic             ntsign_pin,
  input  logic             zpsign_pin,
  input  logic             ptsign_pin,
  output logic             drive,
  output logic             dir
);

  localparam int NW = C_STEP_NUMBER_WIDTH;
  localparam int SW = C_SPEED_DATA_WIDTH;
  localparam logic [NW-1:0] REMAIN_MAX = {1'b0, {(NW-1){1'b1}}};

  axis_state_e          fsm_q;
  logic [NW-1:0]        remain_q;
  logic [NW-1:0]        position_q;
  logic [SW-1:0]        period_q;
  logic [SW-1:0]        cnt_q;
  logic                 rt_dir_q;
  logic                 halt_pend_q;
  logic                 null_run_q;

  logic nt_s, zp_s, pt_s;

  sync2 u_sync_nt (.clk(clk), .resetn(resetn), .din(ntsign_pin), .dout(nt_s));
  sync2 u_sync_zp (.clk(clk), .resetn(resetn), .din(zpsign_pin), .dout(zp_s));
  sync2 u_sync_pt (.clk(clk), .resetn(resetn), .din(ptsign_pin), .dout(pt_s));

  // Displacement is one bit wider so absolute moves across the full range cannot overflow.
  logic signed [NW:0] disp;
  logic        [NW:0] disp_mag;
  logic signed [NW:0] nr_ext;
  logic        [NW:0] nr_mag;
  logic [NW-1:0]      start_remain;
  logic [NW-1:0]      nr_sat;
  logic [SW-1:0]      start_period;
  logic               start_dir;
  logic               start_blocked;
  logic               mod_ok;
  logic               limit_hit;
  logic               period_end;
  logic [SW-1:0]      cnt_next;
  logic [NW-1:0]      rem_dec;
  logic [NW-1:0]      rem_after;
  logic               finish;

  always_comb begin
    disp = ctrl.abs
         ? ($signed({ctrl.step[NW-1], ctrl.step}) - $signed({position_q[NW-1], position_q}))
         : $signed({ctrl.step[NW-1], ctrl.step});
    disp_mag     = disp[NW] ? $unsigned(-disp) : $unsigned(disp);
    start_remain = (disp_mag > {1'b0, REMAIN_MAX}) ? REMAIN_MAX : disp_mag[NW-1:0];
    start_dir    = disp[NW] ? DIR_NEG : DIR_POS;
    start_period = (ctrl.speed < SW'(MIN_PERIOD)) ? SW'(MIN_PERIOD) : ctrl.speed;
    // A zero move or a move straight into an active limit runs one cycle without pulsing.
    start_blocked = (disp == '0) || ((start_dir == DIR_POS) ? pt_s : nt_s);

    nr_ext = $signed({ctrl.new_remain[NW-1], ctrl.new_remain});
    nr_mag = nr_ext[NW] ? $unsigned(-nr_ext) : $unsigned(nr_ext);
    nr_sat = (nr_mag > {1'b0, REMAIN_MAX}) ? REMAIN_MAX : nr_mag[NW-1:0];
    mod_ok = ctrl.mod_remain && (ctrl.new_remain[NW-1] == rt_dir_q);

    limit_hit  = (rt_dir_q == DIR_POS) ? pt_s : nt_s;
    period_end = (cnt_q == period_q - SW'(1));
    cnt_next   = cnt_q + SW'(1);

    // A remain update landing on the period end overrides the decrement.
    rem_dec   = (remain_q == '0) ? '0 : remain_q - NW'(1);
    rem_after = mod_ok ? nr_sat : rem_dec;
    finish    = (rem_after == '0) || halt_pend_q || ctrl.stop || limit_hit;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm_q       <= ST_IDLE;
      remain_q    <= '0;
      position_q  <= '0;
      period_q    <= '0;
      cnt_q       <= '0;
      rt_dir_q    <= DIR_POS;
      halt_pend_q <= 1'b0;
      null_run_q  <= 1'b0;
      drive       <= 1'b0;
    end else if (!ctrl.sel) begin
      // Abort: drop any partial step without counting it.
      fsm_q       <= ST_IDLE;
      cnt_q       <= '0;
      halt_pend_q <= 1'b0;
      null_run_q  <= 1'b0;
      drive       <= 1'b0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (ctrl.start) begin
            fsm_q       <= ST_RUN;
            remain_q    <= start_remain;
            rt_dir_q    <= start_dir;
            period_q    <= start_period;
            cnt_q       <= '0;
            halt_pend_q <= 1'b0;
            null_run_q  <= start_blocked;
            drive       <= !start_blocked;
          end
        end

        ST_RUN: begin
          if (null_run_q) begin
            fsm_q      <= ST_IDLE;
            null_run_q <= 1'b0;
            drive      <= 1'b0;
          end else if (period_end) begin
            position_q <= (rt_dir_q == DIR_NEG) ? position_q - NW'(1) : position_q + NW'(1);
            remain_q   <= rem_after;
            cnt_q      <= '0;
            if (finish) begin
              fsm_q       <= ST_IDLE;
              halt_pend_q <= 1'b0;
              drive       <= 1'b0;
            end else begin
              drive <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_next;
            drive <= (cnt_next < (period_q >> 1));
            if (mod_ok) remain_q <= nr_sat;
            if (ctrl.stop || limit_hit) halt_pend_q <= 1'b1;
          end
        end

        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

  assign ctrl.state    = (fsm_q == ST_RUN);
  assign ctrl.rt_dir   = rt_dir_q;
  assign ctrl.position = position_q;
  assign ctrl.ntsign   = nt_s;
  assign ctrl.zpsign   = zp_s;
  assign ctrl.ptsign   = pt_s;
  assign dir           = rt_dir_q;

endmodule
